// File: rtl/turn_controller.sv
// Turn sequencer for the four-in-a-row board: owns the active player, runs the
// per-turn countdown, issues board strobes and latches the game result.
module turn_controller #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned TURN_SECONDS = 10,
  parameter int unsigned WATCHDOG     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       move_valid,
  input  logic [2:0] move_col,
  input  logic       player_moved,
  input  logic       column_full,
  input  logic       theres_a_winner,
  input  logic       board_full,
  output logic [2:0] selected_col,
  output logic [2:0] col_to_check,
  output logic       current_player,
  output logic       check_col,
  output logic       place_token,
  output logic       place_token_randomly,
  output logic       check_win,
  output logic [3:0] seconds_left,
  output logic       timeout,
  output logic       col_rejected,
  output logic       fault,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       draw
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned WW = (WATCHDOG > 1) ? $clog2(WATCHDOG) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [WW-1:0] WD_LAST    = WW'(WATCHDOG - 1);
  localparam logic [3:0]    SECS_FULL  = 4'(TURN_SECONDS);

  typedef enum logic [3:0] {
    IDLE,
    WAIT_MOVE,
    CHECK_COL,
    PLACE,
    PLACE_RAND,
    WAIT_PLACED,
    CHECK_WIN,
    SWITCH,
    GAME_OVER
  } state_t;

  state_t          state_q, state_d;
  logic            player_q, player_d;
  logic [3:0]      secs_q, secs_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [2:0]      col_q, col_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            rej_q, rej_d;
  logic            fault_q, fault_d;
  logic [1:0]      winner_q, winner_d;
  logic            draw_q, draw_d;

  logic            sec_tick;
  logic            expire;

  assign sec_tick = (presc_q == PRESC_LAST);
  assign expire   = sec_tick && (secs_q <= 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      player_q  <= 1'b0;
      secs_q    <= SECS_FULL;
      presc_q   <= '0;
      col_q     <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      rej_q     <= 1'b0;
      fault_q   <= 1'b0;
      winner_q  <= '0;
      draw_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      player_q  <= player_d;
      secs_q    <= secs_d;
      presc_q   <= presc_d;
      col_q     <= col_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      rej_q     <= rej_d;
      fault_q   <= fault_d;
      winner_q  <= winner_d;
      draw_q    <= draw_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    player_d  = player_q;
    secs_d    = secs_q;
    presc_d   = presc_q;
    col_d     = col_q;
    wd_d      = wd_q;
    timeout_d = 1'b0;
    rej_d     = 1'b0;
    fault_d   = 1'b0;
    winner_d  = winner_q;
    draw_d    = draw_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          player_d = 1'b0;
          secs_d   = SECS_FULL;
          presc_d  = '0;
          state_d  = WAIT_MOVE;
        end
      end

      WAIT_MOVE: begin
        presc_d = sec_tick ? '0 : presc_q + PW'(1);
        if (sec_tick && !expire) begin
          secs_d = secs_q - 4'd1;
        end
        // A move in the expiry cycle wins: the last second is kept, no timeout.
        if (move_valid) begin
          if (move_col != 3'd7) begin
            col_d   = move_col;
            state_d = CHECK_COL;
          end else begin
            rej_d = 1'b1;
          end
        end else if (expire) begin
          secs_d    = '0;
          timeout_d = 1'b1;
          state_d   = PLACE_RAND;
        end
      end

      CHECK_COL: begin
        if (column_full) begin
          rej_d   = 1'b1;
          state_d = WAIT_MOVE;
        end else begin
          state_d = PLACE;
        end
      end

      PLACE, PLACE_RAND: begin
        wd_d    = '0;
        state_d = WAIT_PLACED;
      end

      WAIT_PLACED: begin
        if (player_moved) begin
          state_d = CHECK_WIN;
        end else if (wd_q == WD_LAST) begin
          fault_d = 1'b1;
          secs_d  = SECS_FULL;
          presc_d = '0;
          state_d = WAIT_MOVE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end

      CHECK_WIN: begin
        if (theres_a_winner) begin
          winner_d = {1'b0, player_q} + 2'd1;
          state_d  = GAME_OVER;
        end else if (board_full) begin
          draw_d   = 1'b1;
          winner_d = '0;
          state_d  = GAME_OVER;
        end else begin
          // Handoff is applied on entry so the new player is visible during SWITCH.
          player_d = ~player_q;
          secs_d   = SECS_FULL;
          presc_d  = '0;
          state_d  = SWITCH;
        end
      end

      SWITCH: begin
        state_d = WAIT_MOVE;
      end

      GAME_OVER: begin
        state_d = GAME_OVER;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign selected_col         = col_q;
  assign col_to_check         = col_q;
  assign current_player       = player_q;
  assign check_col            = (state_q == CHECK_COL);
  assign place_token          = (state_q == PLACE);
  assign place_token_randomly = (state_q == PLACE_RAND);
  assign check_win            = (state_q == CHECK_WIN);
  assign seconds_left         = secs_q;
  assign timeout              = timeout_q;
  assign col_rejected         = rej_q;
  assign fault                = fault_q;
  assign game_over            = (state_q == GAME_OVER);
  assign winner               = winner_q;
  assign draw                 = draw_q;

endmodule

// File: tb/tb_turn_controller.sv
// Randomized bench for turn_controller: turns are played against a model that
// tracks elapsed turn time in cycles and derives every output from it.
module tb_turn_controller;

  localparam int unsigned CLK_HZ = 4;
  localparam int unsigned TS     = 3;
  localparam int unsigned WD     = 4;
  localparam int unsigned LIMIT  = CLK_HZ * TS;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       move_valid;
  logic [2:0] move_col;
  logic       player_moved;
  logic       column_full;
  logic       theres_a_winner;
  logic       board_full;
  logic [2:0] selected_col;
  logic [2:0] col_to_check;
  logic       current_player;
  logic       check_col;
  logic       place_token;
  logic       place_token_randomly;
  logic       check_win;
  logic [3:0] seconds_left;
  logic       timeout;
  logic       col_rejected;
  logic       fault;
  logic       game_over;
  logic [1:0] winner;
  logic       draw;

  turn_controller #(
    .CLK_HZ      (CLK_HZ),
    .TURN_SECONDS(TS),
    .WATCHDOG    (WD)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .move_valid          (move_valid),
    .move_col            (move_col),
    .player_moved        (player_moved),
    .column_full         (column_full),
    .theres_a_winner     (theres_a_winner),
    .board_full          (board_full),
    .selected_col        (selected_col),
    .col_to_check        (col_to_check),
    .current_player      (current_player),
    .check_col           (check_col),
    .place_token         (place_token),
    .place_token_randomly(place_token_randomly),
    .check_win           (check_win),
    .seconds_left        (seconds_left),
    .timeout             (timeout),
    .col_rejected        (col_rejected),
    .fault               (fault),
    .game_over           (game_over),
    .winner              (winner),
    .draw                (draw)
  );

  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_bad;

  // Model: m_elapsed counts turn-timer cycles since the last reload.
  int unsigned m_elapsed;
  bit          m_player;
  int unsigned m_col;
  bit          m_over;
  int unsigned m_winner;
  bit          m_draw;
  logic [3:0]  e_strobe;  // {check_col, place_token, place_token_randomly, check_win}
  logic [2:0]  e_pulse;   // {timeout, col_rejected, fault}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("strobes", 32'({check_col, place_token, place_token_randomly, check_win}), 32'(e_strobe));
    check("pulses", 32'({timeout, col_rejected, fault}), 32'(e_pulse));
    check("player", 32'(current_player), 32'(m_player));
    check("seconds", 32'(seconds_left), TS - m_elapsed / CLK_HZ);
    check("selected_col", 32'(selected_col), m_col);
    check("col_to_check", 32'(col_to_check), m_col);
    check("game_over", 32'(game_over), 32'(m_over));
    check("winner", 32'(winner), m_winner);
    check("draw", 32'(draw), 32'(m_draw));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_outputs();
    e_strobe = '0;
    e_pulse  = '0;
  endtask

  task automatic model_reset();
    m_elapsed = 0;
    m_player  = 1'b0;
    m_col     = 0;
    m_over    = 1'b0;
    m_winner  = 0;
    m_draw    = 1'b0;
    e_strobe  = '0;
    e_pulse   = '0;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    start           = 1'b0;
    move_valid      = 1'b0;
    player_moved    = 1'b0;
    column_full     = 1'b0;
    theres_a_winner = 1'b0;
    board_full      = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic start_game();
    repeat ($urandom_range(0, 3)) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // res: 0 = column accepted (now in CHECK_COL), 1 = column 7 rejected, 2 = timed out.
  task automatic wait_move(input int unsigned delay, input logic [2:0] col, output int unsigned res);
    res = 2;
    for (int unsigned i = 0; i <= LIMIT; i++) begin
      if (i == delay) begin
        move_valid = 1'b1;
        move_col   = col;
        m_elapsed  = (m_elapsed + 1 == LIMIT) ? LIMIT - CLK_HZ : m_elapsed + 1;
        if (col == 3'd7) begin
          e_pulse = 3'b010;
          res     = 1;
        end else begin
          e_strobe = 4'b1000;
          m_col    = 32'(col);
          res      = 0;
        end
        tick();
        move_valid = 1'b0;
        return;
      end
      m_elapsed++;
      if (m_elapsed == LIMIT) begin
        e_pulse  = 3'b100;
        e_strobe = 4'b0010;
        tick();
        return;
      end
      tick();
    end
  endtask

  // end_kind: 0 = game continues, 1 = mover wins, 2 = board fills (draw).
  task automatic play_turn(input int unsigned end_kind);
    int unsigned res;
    int unsigned delay;
    int unsigned r;
    int unsigned ack;
    logic [2:0]  col;
    bit          placed;
    bit          faulted;
    for (int unsigned attempt = 0; attempt < 50; attempt++) begin
      placed = 1'b0;
      for (int unsigned tries = 0; tries < 30 && !placed; tries++) begin
        r = $urandom_range(0, 9);
        if (tries == 29)  delay = 0;
        else if (r < 6)   delay = $urandom_range(0, 4);
        else if (r < 8)   delay = LIMIT - 1 - m_elapsed;
        else              delay = LIMIT + 5;
        col = 3'($urandom_range(0, 7));
        if (tries == 29 && col == 3'd7) col = 3'd0;
        wait_move(delay, col, res);
        if (res == 2) begin
          placed = 1'b1;
        end else if (res == 0) begin
          if (tries != 29 && $urandom_range(0, 3) == 0) begin
            column_full = 1'b1;
            e_pulse     = 3'b010;
            tick();
            column_full = 1'b0;
          end else begin
            e_strobe = 4'b0100;
            tick();
            placed = 1'b1;
          end
        end
      end
      tick();
      ack     = ($urandom_range(0, 5) == 0) ? WD : $urandom_range(0, WD - 1);
      faulted = 1'b0;
      for (int unsigned j = 0; j < WD; j++) begin
        if (j == ack) begin
          player_moved = 1'b1;
          e_strobe     = 4'b0001;
          tick();
          player_moved = 1'b0;
          break;
        end
        if (j == WD - 1) begin
          e_pulse   = 3'b001;
          m_elapsed = 0;
          faulted   = 1'b1;
        end
        tick();
      end
      if (!faulted) begin
        theres_a_winner = (end_kind == 1);
        board_full      = (end_kind == 2) || (end_kind == 1 && $urandom_range(0, 1) == 1);
        if (end_kind == 1) begin
          m_over   = 1'b1;
          m_winner = m_player ? 2 : 1;
        end else if (end_kind == 2) begin
          m_over   = 1'b1;
          m_draw   = 1'b1;
          m_winner = 0;
        end else begin
          m_player  = !m_player;
          m_elapsed = 0;
        end
        tick();
        theres_a_winner = 1'b0;
        board_full      = 1'b0;
        if (end_kind == 0) tick();
        return;
      end
    end
  endtask

  task automatic reset_in_wait_placed();
    int unsigned res;
    wait_move(0, 3'd2, res);
    column_full = 1'b0;
    e_strobe    = 4'b0100;
    tick();
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish by %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    int unsigned nt;
    n_vec           = 0;
    n_bad           = 0;
    rst             = 1'b1;
    start           = 1'b0;
    move_valid      = 1'b0;
    move_col        = '0;
    player_moved    = 1'b0;
    column_full     = 1'b0;
    theres_a_winner = 1'b0;
    board_full      = 1'b0;
    model_reset();
    @(posedge clk);

    for (int g = 0; g < 8; g++) begin
      do_reset();
      start_game();
      if (g == 3) begin
        play_turn(0);
        reset_in_wait_placed();
        start_game();
      end
      nt = (g == 0) ? 2 : $urandom_range(1, 5);
      for (int unsigned t = 0; t < nt; t++) begin
        play_turn((t == nt - 1) ? ((g % 2 == 0) ? 1 : 2) : 0);
      end
      for (int i = 0; i < 5; i++) begin
        start      = 1'($urandom_range(0, 1));
        move_valid = 1'($urandom_range(0, 1));
        move_col   = 3'($urandom_range(0, 6));
        tick();
      end
      start      = 1'b0;
      move_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/turn_controller.md
# turn_controller

Game sequencer for the four-in-a-row lab, placed directly upstream of the board block. It owns whose turn it is and runs a per-turn countdown. It converts a player's column selection into the board's check_col / place_token / check_win strobes, forces a random placement on timeout, and latches the game result (win or draw).

## Interface
- CLK_HZ, default 50_000_000: clk cycles per one-second timer tick.
- TURN_SECONDS, default 10: turn time budget in seconds; legal range 1..15.
- WATCHDOG, default 4: maximum cycles to wait for player_moved after a placement strobe.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a game from IDLE.
- move_valid  in  1  one-cycle pulse: the player confirms move_col.
- move_col  in  3  requested column, 0..6.
- player_moved  in  1  board acknowledge; registered, so it arrives at least one cycle after the strobe.
- column_full  in  1  board column status; meaningful only while check_col=1.
- theres_a_winner  in  1  board win flag; meaningful only while check_win=1.
- board_full  in  1  board holds 42 tokens.
- selected_col  out  3  column to place into; the registered copy of the accepted move.
- col_to_check  out  3  same value as selected_col.
- current_player  out  1  0 = player 1, 1 = player 2.
- check_col, place_token, place_token_randomly, check_win  out  1 each  board strobes.
- seconds_left  out  4  remaining turn seconds, for display.
- timeout  out  1  one-cycle pulse when the turn timer expires.
- col_rejected  out  1  one-cycle pulse when the chosen column is full or out of range.
- fault  out  1  one-cycle pulse on a watchdog expiry.
- game_over  out  1  level, set in GAME_OVER.
- winner  out  2  0 = none/draw, 1 = player 1, 2 = player 2.
- draw  out  1  level; the board filled with no winner.

## Operation
- Reset values: every output is 0, state is IDLE, and the prescaler is 0. seconds_left resets to TURN_SECONDS.
- States: IDLE, WAIT_MOVE, CHECK_COL, PLACE, PLACE_RAND, WAIT_PLACED, CHECK_WIN, SWITCH, GAME_OVER.
- IDLE: on start, set current_player=0, reload the timer, and go to WAIT_MOVE.
- WAIT_MOVE: the prescaler counts 0..CLK_HZ-1. Each wrap decrements seconds_left.
  - A decrement from 1 to 0 pulses timeout and goes to PLACE_RAND.
  - move_valid with move_col≤6 latches the column and goes to CHECK_COL.
  - move_valid with move_col=7 pulses col_rejected and stays in WAIT_MOVE.
  - If move_valid and expiry occur in the same cycle, move_valid wins, no timeout pulse is issued, and seconds_left stays at 1.
- CHECK_COL: check_col=1 for one cycle and column_full is sampled that cycle.
  - column_full=1: pulse col_rejected and return to WAIT_MOVE. The timer is not reloaded and the prescaler keeps its value.
  - column_full=0: go to PLACE.
- PLACE: place_token=1 for exactly one cycle, then WAIT_PLACED. PLACE_RAND: place_token_randomly=1 for exactly one cycle, then WAIT_PLACED.
- WAIT_PLACED: player_moved=1 leads to CHECK_WIN. If WATCHDOG cycles pass without it, pulse fault, reload the timer and return to WAIT_MOVE with the same player.
- CHECK_WIN: check_win=1 for one cycle.
  - theres_a_winner=1: winner=current_player+1, go to GAME_OVER.
  - Otherwise, board_full=1: draw=1, winner=0, go to GAME_OVER.
  - Otherwise go to SWITCH.
- SWITCH: toggle current_player, reload seconds_left=TURN_SECONDS, clear the prescaler, go to WAIT_MOVE.
- GAME_OVER: game_over, winner and draw are held. start, move_valid and the timer are ignored. Only rst leaves this state, because the board state is cleared by the same rst.
- The timer is frozen outside WAIT_MOVE.
- Strobes are never asserted together, and at most one strobe is high per cycle.
- Widths: the prescaler is $clog2(CLK_HZ) bits. seconds_left never underflows below 0.

## Timing
- move_valid at cycle n:
  - CHECK_COL at n+1.
  - place_token at n+2.
  - player_moved at n+3 or later.
  - check_win one cycle after player_moved is seen.
  - SWITCH the cycle after that; the new player reaches WAIT_MOVE one cycle later.
- Minimum turn handoff is 6 cycles from move_valid.
- Timeout: the timeout pulse and the PLACE_RAND entry occur on the same edge, and place_token_randomly follows in the next cycle.
- selected_col / col_to_check are stable from CHECK_COL through CHECK_WIN.
- An asynchronous rst in any state, including mid-placement, returns IDLE and the reset values at the next evaluation. No strobe is issued after rst rises.

## Test plan
- CLK_HZ=4, TURN_SECONDS=3: start, then move_valid col=3 at cycle 5 -> check_col at 6, place_token at 7 with selected_col=3; stub player_moved at 8 -> check_win at 9, current_player=1 at 10, seconds_left=3.
- Column full: the stub drives column_full=1 during check_col -> col_rejected pulse, no place_token, and seconds_left continues without reload. move_col=7 -> col_rejected, state stays WAIT_MOVE.
- Timeout: no move for 3×4 cycles -> timeout pulse, seconds_left=0, place_token_randomly the next cycle. Same-cycle move_valid at expiry -> normal placement, no timeout.
- Win: theres_a_winner=1 during player 2's check_win -> game_over=1, winner=2, draw=0. Later start and move_valid are ignored.
- Draw: board_full=1 and no winner at check_win -> draw=1, winner=0. Watchdog: suppress player_moved for 4 cycles -> fault pulse, return to WAIT_MOVE with the same player.
- Reset mid-game: assert rst during WAIT_PLACED -> all outputs 0 and state IDLE. A subsequent start begins with player 0.
